command_responder: RTL and testbench
====================================

// Module: command_responder
// PURPOSE
//  UART reply encoder, the transmit-side counterpart of the command decoder.
//  Accepts one completed transaction: read/write flag, 2-bit error code, 15-bit address, 32-bit read data.
//  Serialises it into a reply frame of 1, 3 or 7 bytes, driving a byte-level uart_tx through a start/done handshake.
//  Sits between the memory/command executor and uart_tx.
// PARAMETERS
//  GAP_CYCLES  2      idle clocks between tx_done and the next tx_start
//  TX_TIMEOUT  20000  max clocks waiting for i_tx_done per byte before abort
// PORTS
//  clock        in   1   system clock
//  reset        in   1   asynchronous, active-low
//  i_start      in   1   request pulse; sampled only in S_IDLE
//  i_readwrite  in   1   1=read reply (includes data), 0=write ack
//  i_error      in   2   0=ok, 1=bad command, 2=no address, 3=data timeout
//  i_address    in   15  transaction address
//  i_data       in   32  read data (ignored for writes/errors)
//  i_tx_done    in   1   uart_tx byte-complete pulse
//  o_tx_byte    out  8   byte to transmit
//  o_tx_start   out  1   one-cycle start pulse to uart_tx
//  o_busy       out  1   high from accept until frame end
//  o_done       out  1   one-cycle pulse, frame finished (or aborted)
//  o_timeout    out  1   one-cycle pulse with o_done when aborted
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, byte index 0, counters 0; reset mid-frame aborts immediately, no o_done.
//  Frame (byte 0 first):
//   - error != 0 : [8'hE0|i_error]                                  1 byte
//   - write ok   : [8'hA0, addr[7:0], {1'b0,addr[14:8]}]            3 bytes
//   - read ok    : [8'hA1, addr[7:0], {1'b0,addr[14:8]},
//                   d[7:0], d[15:8], d[23:16], d[31:24]]            7 bytes
//  - Error takes priority over i_readwrite.
//  - All inputs are captured on the accept edge; later input changes do not affect the frame.
//  States:
//   S_IDLE : o_done<=0, o_timeout<=0; if i_start: capture inputs, o_busy<=1, idx<=0, ->S_SEND.
//   S_SEND : o_tx_byte<=frame[idx], o_tx_start<=1, cnt<=0, ->S_WAIT.
//   S_WAIT : o_tx_start<=0 (start is exactly 1 clock).
//            i_tx_done -> last byte ? S_DONE : (idx++, cnt<=0, ->S_GAP).
//            else if cnt==TX_TIMEOUT-1 -> o_timeout<=1, ->S_DONE; else cnt++.
//   S_GAP  : cnt==GAP_CYCLES-1 ? ->S_SEND : cnt++ (GAP_CYCLES=0 skips straight to S_SEND).
//   S_DONE : o_done<=1, o_busy<=0, ->S_IDLE.
//   default: ->S_IDLE.
//  Handshake and timing:
//   - o_tx_byte holds stable from o_tx_start until the matching i_tx_done.
//   - i_tx_done is ignored outside S_WAIT; so is a done pulse in the same cycle as the start is asserted.
//   - Latency: i_start edge -> first o_tx_start 2 clocks.
//   - Last i_tx_done -> o_done 2 clocks.
//  Boundaries:
//   - i_start while busy is dropped (not queued).
//   - i_start in the S_DONE->S_IDLE cycle is not accepted; it is accepted in S_IDLE on the following cycle.
//   - addr bit 15 of the address byte is always 0.
//   - Timeout leaves remaining bytes unsent; o_done and o_timeout pulse together.
// TESTING
//  1. read, addr=15'h1234, data=32'hDEADBEEF, tx model done 10 clks after start
//     -> bytes A1,34,12,EF,BE,AD,DE, then o_done pulse, o_timeout=0.
//  2. write, addr=15'h7FFF -> A0,FF,7F, 3 start pulses, o_done 2 clks after 3rd done.
//  3. i_error=2 with i_readwrite=1 -> single byte E2, o_done.
//  4. i_start re-pulsed and inputs changed mid-frame
//     -> frame unchanged, no second frame; gap = GAP_CYCLES clks between done and next start.
//  5. tx model never returns done -> after TX_TIMEOUT clks, o_done & o_timeout pulse, o_busy=0.
//  6. reset asserted during byte 4 of a read -> outputs 0 immediately, next i_start sends a full fresh frame.

Source files
------------

// File: rtl/command_responder.sv
// UART reply encoder: captures one completed transaction and serialises it
// as a 1, 3 or 7 byte reply frame through a start/done byte handshake.
module command_responder #(
    parameter int GAP_CYCLES = 2,
    parameter int TX_TIMEOUT = 20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_readwrite,
    input  logic [1:0]  i_error,
    input  logic [14:0] i_address,
    input  logic [31:0] i_data,
    input  logic        i_tx_done,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout
);

    // One counter serves both the per-byte timeout and the inter-byte gap.
    localparam int CNT_MAX = (TX_TIMEOUT > GAP_CYCLES) ? TX_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int GAP_END = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int TO_END  = (TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0;

    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_END);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TO_END);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [1:0]        err_q, err_d;
    logic [14:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              abort_q, abort_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic [7:0]        frame_byte;
    logic [2:0]        frame_last;
    logic              last_byte;

    // Select the frame byte at the current index from the captured transaction.
    always_comb begin
        frame_byte = 8'h00;
        frame_last = 3'd0;
        if (err_q != 2'd0) begin
            frame_byte = {6'b111000, err_q};
            frame_last = 3'd0;
        end else begin
            frame_last = rw_q ? 3'd6 : 3'd2;
            case (idx_q)
                3'd0:    frame_byte = rw_q ? 8'hA1 : 8'hA0;
                3'd1:    frame_byte = addr_q[7:0];
                3'd2:    frame_byte = {1'b0, addr_q[14:8]};
                3'd3:    frame_byte = data_q[7:0];
                3'd4:    frame_byte = data_q[15:8];
                3'd5:    frame_byte = data_q[23:16];
                3'd6:    frame_byte = data_q[31:24];
                default: frame_byte = 8'h00;
            endcase
        end
    end

    assign last_byte = (idx_q == frame_last);

    // Next-state and registered-output logic for the reply FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        err_d      = err_q;
        addr_d     = addr_q;
        data_d     = data_q;
        abort_d    = abort_q;
        tx_byte_d  = tx_byte_q;
        tx_start_d = tx_start_q;
        busy_d     = busy_q;
        done_d     = done_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                done_d    = 1'b0;
                timeout_d = 1'b0;
                // The idle cycle that still shows the o_done pulse refuses a new request.
                if (i_start && !done_q) begin
                    rw_d    = i_readwrite;
                    err_d   = i_error;
                    addr_d  = i_address;
                    data_d  = i_data;
                    abort_d = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = 3'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                tx_byte_d  = frame_byte;
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                tx_start_d = 1'b0;
                // A done coinciding with our own start pulse belongs to nothing we sent.
                if (i_tx_done && !tx_start_q) begin
                    if (last_byte) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        cnt_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? S_SEND : S_GAP;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // Timeout is reported alongside o_done, not one cycle earlier.
                done_d    = 1'b1;
                timeout_d = abort_q;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the capture registers are reset too so a frame can never
            // be built from stale data left over from before reset.
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            err_q      <= 2'd0;
            addr_q     <= 15'd0;
            data_q     <= 32'd0;
            abort_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above.
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            abort_q    <= abort_d;
            tx_byte_q  <= tx_byte_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_tx_byte  = tx_byte_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_command_responder.sv
// Self-checking bench for command_responder: table of directed frames
// followed by hand-written timeout, restart-window and reset sequences.
module tb_command_responder;

    localparam int GAP_CYCLES = 2;
    localparam int TX_TIMEOUT = 64;

    logic        clock;
    logic        reset;
    logic        i_start;
    logic        i_readwrite;
    logic [1:0]  i_error;
    logic [14:0] i_address;
    logic [31:0] i_data;
    logic        i_tx_done;
    logic [7:0]  o_tx_byte;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;

    command_responder #(
        .GAP_CYCLES(GAP_CYCLES),
        .TX_TIMEOUT(TX_TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .i_start     (i_start),
        .i_readwrite (i_readwrite),
        .i_error     (i_error),
        .i_address   (i_address),
        .i_data      (i_data),
        .i_tx_done   (i_tx_done),
        .o_tx_byte   (o_tx_byte),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_timeout   (o_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic            rw;
        logic [1:0]      err;
        logic [14:0]     addr;
        logic [31:0]     data;
        int              delay;   // clocks from o_tx_start to the model's i_tx_done
        bit              noise;   // drive i_tx_done whenever the DUT should ignore it
        bit              mutate;  // re-pulse i_start and change inputs mid-frame
        int              len;
        logic [6:0][7:0] exp;     // exp[0] is the first byte on the wire
    } vec_t;

    // Results of the last run_frame call (cycle 0 = the cycle i_start was driven).
    logic [7:0] got_q[$];
    int first_start, last_done_cyc, done_lat, done_at, gap_bad, n_starts, stable_bad;
    bit saw_done, saw_to, busy_at_done;

    task automatic launch(input logic rw, input logic [1:0] err, input logic [14:0] addr,
                          input logic [31:0] data);
        @(negedge clock);
        i_readwrite = rw;
        i_error     = err;
        i_address   = addr;
        i_data      = data;
        i_start     = 1'b1;
    endtask

    // Byte-level uart_tx model: answers each start after 'delay' clocks
    // (never if delay <= 0), stops at o_done, after stop_after starts, or
    // when the cycle budget runs out.
    task automatic run_frame(input int delay, input bit noise, input bit mutate,
                             input int stop_after, input int budget);
        int         countdown;
        bit         pending;
        logic [7:0] held;
        got_q.delete();
        first_start = -1; last_done_cyc = -1; done_lat = -1; done_at = -1;
        gap_bad = 0; n_starts = 0; stable_bad = 0;
        saw_done = 0; saw_to = 0; busy_at_done = 0;
        pending = 0; countdown = 0; held = 8'h00;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clock);
            if (cyc == 1) i_start = 1'b0;
            if (mutate && cyc == 5) begin
                i_start     = 1'b1;
                i_readwrite = ~i_readwrite;
                i_error     = 2'd0;
                i_address   = ~i_address;
                i_data      = ~i_data;
            end
            if (mutate && cyc == 6) i_start = 1'b0;
            i_tx_done = 1'b0;
            if (o_done) begin
                saw_done     = 1;
                saw_to       = o_timeout;
                busy_at_done = o_busy;
                done_at      = cyc;
                if (last_done_cyc >= 0) done_lat = cyc - last_done_cyc;
                break;
            end
            if (o_tx_start) begin
                n_starts++;
                got_q.push_back(o_tx_byte);
                held = o_tx_byte;
                if (first_start < 0) first_start = cyc;
                else if (cyc - last_done_cyc != GAP_CYCLES + 2) gap_bad++;
                pending   = (delay > 0);
                countdown = delay;
                if (stop_after != 0 && n_starts == stop_after) return;
                if (noise) i_tx_done = 1'b1;
            end else if (pending) begin
                if (o_tx_byte !== held) stable_bad++;
                countdown--;
                if (countdown == 0) begin
                    i_tx_done     = 1'b1;
                    pending       = 0;
                    last_done_cyc = cyc;
                end
            end else if (noise) begin
                i_tx_done = 1'b1;
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet_bad;

        vecs[0] = '{rw:1'b1, err:2'd0, addr:15'h1234, data:32'hDEADBEEF, delay:10, noise:1'b0,
                    mutate:1'b0, len:7, exp:{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'hA1}};
        vecs[1] = '{rw:1'b0, err:2'd0, addr:15'h7FFF, data:32'h0, delay:3, noise:1'b0,
                    mutate:1'b0, len:3, exp:{32'h0, 8'h7F, 8'hFF, 8'hA0}};
        vecs[2] = '{rw:1'b1, err:2'd2, addr:15'h1111, data:32'h12345678, delay:4, noise:1'b0,
                    mutate:1'b0, len:1, exp:{48'h0, 8'hE2}};
        vecs[3] = '{rw:1'b1, err:2'd0, addr:15'h5A5A, data:32'h01234567, delay:4, noise:1'b0,
                    mutate:1'b1, len:7, exp:{8'h01, 8'h23, 8'h45, 8'h67, 8'h5A, 8'h5A, 8'hA1}};
        vecs[4] = '{rw:1'b0, err:2'd1, addr:15'h0001, data:32'hFFFFFFFF, delay:2, noise:1'b0,
                    mutate:1'b0, len:1, exp:{48'h0, 8'hE1}};
        vecs[5] = '{rw:1'b1, err:2'd3, addr:15'h7FFF, data:32'hCAFEF00D, delay:5, noise:1'b0,
                    mutate:1'b0, len:1, exp:{48'h0, 8'hE3}};
        vecs[6] = '{rw:1'b0, err:2'd0, addr:15'h0080, data:32'h0, delay:1, noise:1'b1,
                    mutate:1'b0, len:3, exp:{32'h0, 8'h00, 8'h80, 8'hA0}};
        vecs[7] = '{rw:1'b1, err:2'd0, addr:15'h4000, data:32'hFFFFFFFF, delay:2, noise:1'b1,
                    mutate:1'b0, len:7, exp:{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h00, 8'hA1}};

        reset = 1'b0; i_start = 1'b0; i_readwrite = 1'b0; i_error = 2'd0;
        i_address = 15'd0; i_data = 32'd0; i_tx_done = 1'b0;
        #1;
        check("reset_outputs", {o_tx_byte, o_tx_start, o_busy, o_done, o_timeout}, 32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("idle_after_reset", {o_tx_start, o_busy, o_done}, 32'h0);

        // Table-driven frames.
        for (int v = 0; v < 8; v++) begin
            launch(vecs[v].rw, vecs[v].err, vecs[v].addr, vecs[v].data);
            run_frame(vecs[v].delay, vecs[v].noise, vecs[v].mutate, 0, 300);
            check($sformatf("v%0d_done_seen", v), saw_done, 1);
            check($sformatf("v%0d_byte_count", v), n_starts, vecs[v].len);
            for (int b = 0; b < vecs[v].len; b++) begin
                logic [7:0] got_b;
                got_b = (b < got_q.size()) ? got_q[b] : 8'hxx;
                check($sformatf("v%0d_byte%0d", v, b), got_b, vecs[v].exp[b]);
            end
            check($sformatf("v%0d_timeout", v), saw_to, 0);
            check($sformatf("v%0d_busy_at_done", v), busy_at_done, 0);
            // i_start driven in cycle 0 -> accepted at the next edge -> start visible in cycle 2.
            check($sformatf("v%0d_start_latency", v), first_start, 2);
            // last i_tx_done in cycle d -> S_DONE in d+1 -> o_done visible in d+2.
            check($sformatf("v%0d_done_latency", v), done_lat, 2);
            // done in cycle d -> GAP_CYCLES gap cycles, one send cycle -> next start at d+GAP_CYCLES+2.
            check($sformatf("v%0d_gap", v), gap_bad, 0);
            check($sformatf("v%0d_byte_stable", v), stable_bad, 0);
            if (vecs[v].mutate) begin
                quiet_bad = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clock);
                    if (o_tx_start || o_busy) quiet_bad++;
                end
                check($sformatf("v%0d_no_second_frame", v), quiet_bad, 0);
            end
        end

        // Timeout: the model never answers.
        launch(1'b0, 2'd0, 15'h0123, 32'h0);
        run_frame(0, 1'b0, 1'b0, 0, TX_TIMEOUT + 40);
        check("to_done_seen", saw_done, 1);
        check("to_timeout_flag", saw_to, 1);
        check("to_busy_low", busy_at_done, 0);
        check("to_single_start", n_starts, 1);
        // start visible in c, WAIT runs TX_TIMEOUT cycles, S_DONE one more, o_done at c+TX_TIMEOUT+1.
        check("to_duration", done_at - first_start, TX_TIMEOUT + 1);
        @(negedge clock);
        check("to_pulse_one_cycle", {o_done, o_timeout}, 32'h0);

        // i_start in the o_done cycle is refused; held one more cycle it is accepted.
        launch(1'b0, 2'd1, 15'h0000, 32'h0);
        run_frame(2, 1'b0, 1'b0, 0, 100);
        check("rw_first_done", saw_done, 1);
        i_error = 2'd3;
        i_start = 1'b1;
        @(negedge clock);
        check("rw_refused_in_done_cycle", o_busy, 0);
        @(negedge clock);
        check("rw_accepted_next_cycle", o_busy, 1);
        run_frame(3, 1'b0, 1'b0, 0, 100);
        check("rw_frame_done", saw_done, 1);
        check("rw_frame_len", n_starts, 1);
        check("rw_frame_byte", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'hE3);

        // Reset asserted while byte index 3 (fourth byte) of a read is in flight.
        launch(1'b1, 2'd0, 15'h1234, 32'hDEADBEEF);
        run_frame(3, 1'b0, 1'b0, 4, 200);
        check("rst_reached_byte4", n_starts, 4);
        reset = 1'b0;
        #1;
        check("rst_outputs_cleared", {o_tx_byte, o_tx_start, o_busy, o_done, o_timeout}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        quiet_bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (o_done || o_busy || o_tx_start) quiet_bad++;
        end
        check("rst_no_done_after", quiet_bad, 0);
        launch(1'b1, 2'd0, 15'h1234, 32'hDEADBEEF);
        run_frame(4, 1'b0, 1'b0, 0, 300);
        check("rst_fresh_done", saw_done, 1);
        check("rst_fresh_len", n_starts, 7);
        for (int b = 0; b < 7; b++) begin
            logic [7:0] got_b;
            got_b = (b < got_q.size()) ? got_q[b] : 8'hxx;
            check($sformatf("rst_fresh_byte%0d", b), got_b, vecs[0].exp[b]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
